// File: rtl/rv32i_dmem_ctrl.sv
// RV32I data-memory responder: drives a byte-enabled synchronous RAM, stalls the pipeline, and returns extended load data.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module rv32i_dmem_ctrl #(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ce,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned BEW   = 4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_mode;
  logic [1:0]         r_a;
  logic               r_rvalid;
  logic [DW-1:0]      r_rdata;
  logic               r_ram_ce;
  logic               r_ram_we;
  logic [BEW-1:0]     r_ram_be;
  logic [RAM_AW-1:0]  r_ram_addr;
  logic [DW-1:0]      r_ram_wdata;

  logic               w_is_byte;
  logic               w_is_half;
  logic [1:0]         w_a_eff;
  logic [BEW-1:0]     w_be;
  logic [DW-1:0]      w_wdata;
  logic               w_trap;
  logic [7:0]         w_ld_b;
  logic [15:0]        w_ld_h;
  logic [DW-1:0]      w_ld_ext;
  logic               w_unused_addr;

  // Address bits above the RAM window alias and are intentionally dropped
  assign w_unused_addr = &{1'b0, req_addr[31:RAM_AW+2]};

  // Request decode: access size, effective lane, byte enables, replicated store data
  always_comb begin
    w_is_byte = (req_mode[1:0] == 2'b00);
    w_is_half = (req_mode[1:0] == 2'b01);
    if (w_is_byte) begin
      w_a_eff = req_addr[1:0];
      w_be    = BEW'(4'b0001 << req_addr[1:0]);
      w_wdata = {4{req_wdata[7:0]}};
    end else if (w_is_half) begin
      w_a_eff = {req_addr[1], 1'b0};
      w_be    = BEW'(4'b0011 << {req_addr[1], 1'b0});
      w_wdata = {2{req_wdata[15:0]}};
    end else begin
      w_a_eff = 2'b00;
      w_be    = 4'b1111;
      w_wdata = req_wdata;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = (w_is_half & req_addr[0]) |
                  (~w_is_byte & ~w_is_half & (req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Load lane extraction and sign/zero extension
  always_comb begin
    w_ld_b = ram_rdata[{r_a, 3'b000} +: 8];
    w_ld_h = r_a[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (r_mode[1:0])
      2'b00:   w_ld_ext = {{24{~r_mode[2] & w_ld_b[7]}}, w_ld_b};
      2'b01:   w_ld_ext = {{16{~r_mode[2] & w_ld_h[15]}}, w_ld_h};
      default: w_ld_ext = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and combinational stall
  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = req_ce;
        if (req_ce) w_next = w_trap ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        stall_o = 1'b1;
        w_next  = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, RAM strobes, counter and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_mode      <= '0;
      r_a         <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_ram_ce    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_be    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_ce <= 1'b0;
      r_ram_we <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_ce) begin
            r_we   <= req_we;
            r_mode <= req_mode;
            r_a    <= w_a_eff;
            if (!w_trap) begin
              r_ram_ce    <= 1'b1;
              r_ram_we    <= req_we;
              r_ram_be    <= w_be;
              r_ram_addr  <= req_addr[RAM_AW+1:2];
              r_ram_wdata <= w_wdata;
            end
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(RD_LAT);
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rdata  <= w_ld_ext;
            r_rvalid <= 1'b1;
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= (r_state == S_IDLE) & req_ce & w_trap;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign ram_ce    = r_ram_ce;
  assign ram_we    = r_ram_we;
  assign ram_be    = r_ram_be;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Directed scoreboard bench for rv32i_dmem_ctrl: RD_LAT=1 instance for the main flow, RD_LAT=3 instance for latency and reset.
module tb_rv32i_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT = 1 instance
  logic        rst = 1'b1;
  logic        req_ce = 1'b0, req_we = 1'b0;
  logic [2:0]  req_mode = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall_o, rvalid_o, err_o, ram_ce, ram_we;
  logic [31:0] rdata_o, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic [9:0]  ram_addr;

  // RD_LAT = 3 instance
  logic        rst3 = 1'b1;
  logic        req_ce3 = 1'b0, req_we3 = 1'b0;
  logic [2:0]  req_mode3 = 3'b0;
  logic [31:0] req_addr3 = '0, req_wdata3 = '0;
  logic        stall3, rvalid3, err3, ram_ce3, ram_we3;
  logic [31:0] rdata3, ram_wdata3, ram_rdata3;
  logic [3:0]  ram_be3;
  logic [9:0]  ram_addr3;

  rv32i_dmem_ctrl #(.RAM_AW(10), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_ce(req_ce), .req_we(req_we), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_o(stall_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .ram_ce(ram_ce), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  rv32i_dmem_ctrl #(.RAM_AW(10), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_ce(req_ce3), .req_we(req_we3), .req_mode(req_mode3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .stall_o(stall3), .rvalid_o(rvalid3),
    .rdata_o(rdata3), .err_o(err3), .ram_ce(ram_ce3), .ram_we(ram_we3), .ram_be(ram_be3),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  // Byte-enabled RAM models: 1-cycle and 3-cycle read latency
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] s1, s2;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem1[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_rdata <= mem1[ram_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (ram_ce3 && ram_we3) begin
      for (int b = 0; b < 4; b++)
        if (ram_be3[b]) mem3[ram_addr3][b*8 +: 8] <= ram_wdata3[b*8 +: 8];
    end
    s1         <= (ram_ce3 && !ram_we3) ? mem3[ram_addr3] : 32'hBAD0BAD0;
    s2         <= s1;
    ram_rdata3 <= s2;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  logic [3:0]  obs_be;
  logic [9:0]  obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every load result pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      if (sb.size() == 0) check("rvalid_unexpected", 32'(rvalid_o), 32'd0);
      else                check("load_rdata", rdata_o, sb.pop_front());
    end
  end

  // Drive one request from IDLE; count stall cycles and RAM strobes, check DONE-cycle outputs
  task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wd, input int exp_stall, input logic exp_err,
                        input logic exp_rvalid);
    int n = 0;
    int ce = 0;
    req_ce = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall_o !== 1'b1) break;
      n++;
      if (ram_ce === 1'b1) begin
        ce++;
        obs_be = ram_be; obs_addr = ram_addr; obs_wdata = ram_wdata; obs_we = ram_we;
      end
      @(posedge clk); #1;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    check("ram_ce_count", 32'(ce), exp_err ? 32'd0 : 32'd1);
    check("done_err_o", 32'(err_o), 32'(exp_err));
    check("done_rvalid_o", 32'(rvalid_o), 32'(exp_rvalid));
    check("done_ram_ce", 32'(ram_ce), 32'd0);
    @(posedge clk); #1;
    req_ce = 1'b0;
  endtask

  initial begin
    int n3;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_rvalid", 32'(rvalid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_ram_ce", 32'(ram_ce), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_be", 32'(ram_be), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", ram_wdata, 0);
    @(posedge clk); #1;

    // SW then LW at 0x100
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 1'b0, 1'b0);
    check("sw_be", 32'(obs_be), 32'hF);
    check("sw_addr", 32'(obs_addr), 32'h40);
    check("sw_we", 32'(obs_we), 1);
    check("sw_wdata", obs_wdata, 32'hDEADBEEF);
    sb.push_back(32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b0, 1'b1);
    check("lw_be", 32'(obs_be), 32'hF);
    check("lw_addr", 32'(obs_addr), 32'h40);
    check("lw_we", 32'(obs_we), 0);

    // Byte lane 3, positive then negative value
    do_req(1'b1, 3'b000, 32'h103, 32'h0000005A, 2, 1'b0, 1'b0);
    check("sb_be", 32'(obs_be), 32'h8);
    check("sb_wdata", obs_wdata, 32'h5A5A5A5A);
    sb.push_back(32'h0000005A);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 3, 1'b0, 1'b1);
    sb.push_back(32'h0000005A);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 3, 1'b0, 1'b1);
    do_req(1'b1, 3'b000, 32'h103, 32'h00000080, 2, 1'b0, 1'b0);
    sb.push_back(32'hFFFFFF80);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 3, 1'b0, 1'b1);
    sb.push_back(32'h00000080);
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 3, 1'b0, 1'b1);

    // Upper half-word
    do_req(1'b1, 3'b001, 32'h202, 32'h00008001, 2, 1'b0, 1'b0);
    check("sh_be", 32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'h80018001);
    sb.push_back(32'hFFFF8001);
    do_req(1'b0, 3'b001, 32'h202, 32'h0, 3, 1'b0, 1'b1);
    sb.push_back(32'h00008001);
    do_req(1'b0, 3'b101, 32'h202, 32'h0, 3, 1'b0, 1'b1);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b1, 1'b0);
    check("trap_rdata_held", rdata_o, 32'h00008001);
    do_req(1'b0, 3'b001, 32'h203, 32'h0, 1, 1'b1, 1'b0);
`else
    // Word 0x40 holds DEADBEEF with byte 3 overwritten by the last SB (0x80)
    sb.push_back(32'h80ADBEEF);
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 3, 1'b0, 1'b1);
    check("mis_lw_be", 32'(obs_be), 32'hF);
    check("mis_lw_addr", 32'(obs_addr), 32'h40);
    sb.push_back(32'hFFFF8001);
    do_req(1'b0, 3'b001, 32'h203, 32'h0, 3, 1'b0, 1'b1);
    check("mis_lh_be", 32'(obs_be), 32'hC);
`endif

    // Back-to-back LW 0x0 then SW 0x4 with no idle gap
    do_req(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 2, 1'b0, 1'b0);
    sb.push_back(32'hCAFEF00D);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, 3, 1'b0, 1'b1);
    do_req(1'b1, 3'b010, 32'h4, 32'h11223344, 2, 1'b0, 1'b0);
    check("b2b_sw_addr", 32'(obs_addr), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 0);

    // RD_LAT=3: seed word, then load with 5-cycle stall
    req_ce3 = 1'b1; req_we3 = 1'b1; req_mode3 = 3'b010; req_addr3 = 32'h14; req_wdata3 = 32'h12345678;
    repeat (2) @(posedge clk);
    #1; req_ce3 = 1'b0;
    @(posedge clk); #1;
    req_ce3 = 1'b1; req_we3 = 1'b0;
    n3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall3 !== 1'b1) break;
      n3++;
      check("lat3_no_early_rvalid", 32'(rvalid3), 0);
      @(posedge clk); #1;
    end
    check("lat3_stall_cycles", 32'(n3), 5);
    check("lat3_rvalid", 32'(rvalid3), 1);
    check("lat3_rdata", rdata3, 32'h12345678);
    @(posedge clk); #1;
    req_ce3 = 1'b0;

    // Reset while a read is in flight
    @(posedge clk); #1;
    req_ce3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1; req_ce3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    check("rst3_stall", 32'(stall3), 0);
    check("rst3_rvalid", 32'(rvalid3), 0);
    check("rst3_err", 32'(err3), 0);
    check("rst3_ram_ce", 32'(ram_ce3), 0);
    check("rst3_ram_we", 32'(ram_we3), 0);
    check("rst3_ram_be", 32'(ram_be3), 0);
    check("rst3_rdata", rdata3, 0);
    check("rst3_ram_addr", 32'(ram_addr3), 0);
    check("rst3_ram_wdata", ram_wdata3, 0);
    n3 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid3 === 1'b1 || ram_ce3 === 1'b1) n3++;
    end
    check("rst3_no_activity", 32'(n3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
